// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised sequence detector.
// The helpers build the KMP transition table from the pattern.
package seq_det_pkg;

    localparam int unsigned MAX_PAT_LEN = 16;
    localparam int unsigned MIN_PAT_LEN = 2;
    localparam int unsigned IDX_W       = $clog2(MAX_PAT_LEN);

    // Bit i of the pattern in arrival order (i=0 is the first bit received, i.e. the MSB).
    function automatic logic pat_bit(input logic [MAX_PAT_LEN-1:0] pattern,
                                     input int unsigned len, input int unsigned i);
        return pattern[IDX_W'(len - 1 - i)];
    endfunction

    // Longest pattern prefix that is a suffix of (first s pattern bits, then b); len means full match.
    function automatic int unsigned next_state(input logic [MAX_PAT_LEN-1:0] pattern,
                                               input int unsigned len, input int unsigned s,
                                               input logic b);
        int unsigned res;
        int unsigned j;
        logic        ok;
        logic        cbit;
        res = 0;
        if (s < len) begin
            for (int unsigned k = 1; k <= MAX_PAT_LEN; k++) begin
                if (k <= s + 1 && k <= len) begin
                    ok = 1'b1;
                    for (int unsigned i = 0; i < MAX_PAT_LEN; i++) begin
                        if (i < k) begin
                            j    = s + 1 - k + i;
                            cbit = (j == s) ? b : pat_bit(pattern, len, j);
                            if (cbit != pat_bit(pattern, len, i)) ok = 1'b0;
                        end
                    end
                    if (ok) res = k;
                end
            end
        end
        return res;
    endfunction

    // Longest proper border of the full pattern: the state to resume from after an overlapping match.
    function automatic int unsigned fail_state(input logic [MAX_PAT_LEN-1:0] pattern,
                                               input int unsigned len);
        int unsigned res;
        logic        ok;
        res = 0;
        for (int unsigned k = 1; k < MAX_PAT_LEN; k++) begin
            if (k < len) begin
                ok = 1'b1;
                for (int unsigned i = 0; i < MAX_PAT_LEN; i++) begin
                    if (i < k && pat_bit(pattern, len, len - k + i) != pat_bit(pattern, len, i))
                        ok = 1'b0;
                end
                if (ok) res = k;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating match counter with a sticky saturation flag and a clear that never drops
// an increment arriving in the same cycle.
module seq_det_sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= inc ? CNT_ONE : '0;
            sat <= inc && (CNT_MAX == CNT_ONE);
        end else if (inc && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
            if (cnt + CNT_ONE == CNT_MAX) sat <= 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector: KMP state machine over a qualified bit stream,
// Moore or Mealy match pulse, and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter bit                 MOORE   = 1'b1,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x_valid,
    input  logic             x_in,
    input  logic             clear_cnt,
    output logic             y_out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int unsigned              STATE_W   = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam int unsigned              NUM_SLOTS = 1 << STATE_W;
    localparam logic [MAX_PAT_LEN-1:0]   PAT_EXT   = MAX_PAT_LEN'(PATTERN);
    localparam int unsigned              FAIL      = fail_state(PAT_EXT, PAT_LEN);

    if (PAT_LEN < MIN_PAT_LEN || PAT_LEN > MAX_PAT_LEN) begin : g_bad_len
        $error("seq_detector_param: PAT_LEN must be in 2..16");
    end

    logic [NUM_SLOTS-1:0][1:0][STATE_W-1:0] trans_tbl;
    logic [NUM_SLOTS-1:0][1:0]              hit_tbl;
    logic [STATE_W-1:0]                     state_q;
    logic [STATE_W-1:0]                     state_d;
    logic                                   match_c;

    // Constant transition table; unreachable slots fall back to state 0.
    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam int unsigned NS = next_state(PAT_EXT, PAT_LEN, s, 1'(b));
            assign hit_tbl[s][b]   = (NS == PAT_LEN);
            assign trans_tbl[s][b] = (NS == PAT_LEN) ? (OVERLAP ? STATE_W'(FAIL) : '0)
                                                     : STATE_W'(NS);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) state_q <= '0;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        match_c = 1'b0;
        if (x_valid) begin
            state_d = trans_tbl[state_q][x_in];
            match_c = hit_tbl[state_q][x_in];
        end
    end

    if (MOORE) begin : g_moore
        logic y_q;
        always_ff @(posedge clock) begin
            if (!reset) y_q <= 1'b0;
            else        y_q <= match_c;
        end
        assign y_out = y_q;
    end else begin : g_mealy
        assign y_out = reset & match_c;
    end

    seq_det_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (match_c),
        .clr   (clear_cnt),
        .cnt   (match_cnt),
        .sat   (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: five configurations driven in lockstep and compared
// against a bit-history reference model, plus fixed vectors and corner-case sequences.
module tb_seq_detector_param;

    localparam int unsigned N_DUT = 5;

    logic clock;
    logic reset, x_valid, x_in, clear_cnt;
    logic [N_DUT-1:0] y;
    logic [N_DUT-1:0] sat;
    logic [7:0] cnt_a, cnt_b, cnt_d;
    logic [1:0] cnt_c;
    logic [2:0] cnt_e;
    logic mealy_pre;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // a: defaults, b: no overlap, c: 2-bit counter, d: Mealy, e: 5-bit pattern 11011
    int unsigned m_len   [N_DUT] = '{4, 4, 4, 4, 5};
    int unsigned m_pat   [N_DUT] = '{32'hB, 32'hB, 32'hB, 32'hB, 32'h1B};
    bit          m_ov    [N_DUT] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bit          m_moore [N_DUT] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int unsigned m_max   [N_DUT] = '{255, 255, 3, 255, 7};

    logic [15:0] m_hist  [N_DUT];
    int unsigned m_since [N_DUT];
    int unsigned m_cnt   [N_DUT];
    logic        m_sat   [N_DUT];
    logic        m_y     [N_DUT];

    typedef struct {
        logic        r;
        logic        v;
        logic        b;
        logic        c;
        logic        exp_y;
        int unsigned exp_cnt;
    } vec_t;
    vec_t tbl [9];

    initial clock = 1'b0;
    always #10 clock = ~clock;

    seq_detector_param u_a (
        .clock(clock), .reset(reset), .x_valid(x_valid), .x_in(x_in), .clear_cnt(clear_cnt),
        .y_out(y[0]), .match_cnt(cnt_a), .cnt_sat(sat[0]));

    seq_detector_param #(.OVERLAP(1'b0)) u_b (
        .clock(clock), .reset(reset), .x_valid(x_valid), .x_in(x_in), .clear_cnt(clear_cnt),
        .y_out(y[1]), .match_cnt(cnt_b), .cnt_sat(sat[1]));

    seq_detector_param #(.CNT_W(2)) u_c (
        .clock(clock), .reset(reset), .x_valid(x_valid), .x_in(x_in), .clear_cnt(clear_cnt),
        .y_out(y[2]), .match_cnt(cnt_c), .cnt_sat(sat[2]));

    seq_detector_param #(.MOORE(1'b0)) u_d (
        .clock(clock), .reset(reset), .x_valid(x_valid), .x_in(x_in), .clear_cnt(clear_cnt),
        .y_out(y[3]), .match_cnt(cnt_d), .cnt_sat(sat[3]));

    seq_detector_param #(.PAT_LEN(5), .PATTERN(5'b11011), .CNT_W(3)) u_e (
        .clock(clock), .reset(reset), .x_valid(x_valid), .x_in(x_in), .clear_cnt(clear_cnt),
        .y_out(y[4]), .match_cnt(cnt_e), .cnt_sat(sat[4]));

    function automatic int unsigned get_cnt(input int i);
        case (i)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            2:       return int'(cnt_c);
            3:       return int'(cnt_d);
            default: return int'(cnt_e);
        endcase
    endfunction

    // Match iff the last PAT_LEN accepted bits equal the pattern and all arrived since the last restart.
    function automatic logic model_match(input int i, input logic r, input logic v, input logic b);
        logic [15:0] cand;
        logic [15:0] mask;
        cand = {m_hist[i][14:0], b};
        mask = 16'((32'd1 << m_len[i]) - 32'd1);
        return r && v && (m_since[i] + 1 >= m_len[i]) && ((cand & mask) == 16'(m_pat[i]));
    endfunction

    task automatic check(input string name, input int idx, input int unsigned act,
                         input int unsigned exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic b, input logic c);
        logic [N_DUT-1:0] hit;
        @(negedge clock);
        reset = r; x_valid = v; x_in = b; clear_cnt = c;
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            hit[i] = model_match(i, r, v, b);
            if (!m_moore[i]) check("mealy_y", i, y[i], hit[i]);
        end
        mealy_pre = y[3];
        @(posedge clock);
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            if (!r) begin
                m_hist[i] = '0; m_since[i] = 0; m_cnt[i] = 0; m_sat[i] = 1'b0; m_y[i] = 1'b0;
            end else begin
                if (v) begin
                    m_hist[i] = {m_hist[i][14:0], b};
                    if (m_since[i] < 16) m_since[i]++;
                end
                if (hit[i] && !m_ov[i]) m_since[i] = 0;
                if (c) begin
                    m_cnt[i] = hit[i] ? 1 : 0;
                    m_sat[i] = 1'b0;
                end else if (hit[i] && m_cnt[i] < m_max[i]) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == m_max[i]) m_sat[i] = 1'b1;
                end
                m_y[i] = hit[i];
            end
            check("match_cnt", i, get_cnt(i), m_cnt[i]);
            check("cnt_sat", i, sat[i], m_sat[i]);
            if (m_moore[i]) check("moore_y", i, y[i], m_y[i]);
        end
    endtask

    task automatic bits(input logic [15:0] seq, input int n);
        for (int k = n - 1; k >= 0; k--) step(1'b1, 1'b1, seq[k], 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; x_valid = 1'b0; x_in = 1'b0; clear_cnt = 1'b0; mealy_pre = 1'b0;
        for (int i = 0; i < N_DUT; i++) begin
            m_hist[i] = '0; m_since[i] = 0; m_cnt[i] = 0; m_sat[i] = 1'b0; m_y[i] = 1'b0;
        end

        // Reset with x_in=1/x_valid=1, then stream 1011011 on the default instance
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2};
        for (int k = 0; k < 9; k++) begin
            step(tbl[k].r, tbl[k].v, tbl[k].b, tbl[k].c);
            check("tbl_y", 0, y[0], tbl[k].exp_y);
            check("tbl_cnt", 0, cnt_a, tbl[k].exp_cnt);
            check("tbl_sat", 0, sat[0], 0);
        end
        check("t2_nooverlap_cnt", 1, cnt_b, 1);

        // Qualifier: bits ignored while x_valid is low
        step(1'b0, 1'b1, 1'b1, 1'b0);
        bits(16'b10, 2);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'(k % 2 == 0), 1'b0);
            check("t3_mealy_novalid", 3, mealy_pre, 0);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("t3_cnt_before", 0, cnt_a, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("t3_cnt", 0, cnt_a, 1);
        check("t3_y", 0, y[0], 1);
        check("t6_mealy_hit", 3, mealy_pre, 1);

        // Reset mid-pattern discards the partial 101
        step(1'b0, 1'b1, 1'b1, 1'b0);
        bits(16'b101, 3);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("t4_rst_cnt", 0, cnt_a, 0);
        check("t4_rst_y", 0, y[0], 0);
        bits(16'b011, 3);
        check("t4_partial_cnt", 0, cnt_a, 0);
        check("t4_partial_y", 0, y[0], 0);
        bits(16'b1011, 4);
        check("t4_full_cnt", 0, cnt_a, 1);

        // Saturation at 3 on the 2-bit counter, then clear on a match edge
        step(1'b0, 1'b1, 1'b0, 1'b0);
        bits(16'b1011011011011011, 16);
        check("t5_sat_cnt", 2, cnt_c, 3);
        check("t5_sat_flag", 2, sat[2], 1);
        check("t5_wide_cnt", 0, cnt_a, 5);
        bits(16'b01, 2);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("t5_clr_cnt", 2, cnt_c, 1);
        check("t5_clr_flag", 2, sat[2], 0);

        // Mealy: fourth bit 0 gives no pulse, valid low gives no pulse
        step(1'b0, 1'b1, 1'b0, 1'b0);
        bits(16'b101, 3);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("t6_mealy_valid0", 3, mealy_pre, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t6_mealy_bit0", 3, mealy_pre, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("t6_mealy_match", 3, mealy_pre, 1);

        // Randomised traffic against the reference model
        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom_range(99) != 0), 1'($urandom_range(3) != 0),
                 1'($urandom_range(1)), 1'($urandom_range(49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
